nios2_oci_mem_access: RTL and testbench

NIOS2_OCI_MEM_ACCESS -- requirements
Module: nios2_oci_mem_access

---
 rtl/nios2_oci_pkg.sv | 22 ++
 rtl/nios2_oci_mem_watchdog.sv | 32 +++
 rtl/nios2_oci_mem_access.sv | 124 ++++++++++++
 tb/tb_nios2_oci_mem_access.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_pkg.sv
// nios2_oci_pkg: shared types and constants for the OCI debug-memory access block.
// Holds the access FSM state encoding, the jdo command-word field positions
// and the data word loaded into MonDReg when a transfer times out.
package nios2_oci_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } mem_state_e;

    // jdo field positions; the address field sits inside the write-data field
    localparam int JDO_RD_BIT   = 35;
    localparam int JDO_WDATA_HI = 34;
    localparam int JDO_WDATA_LO = 3;
    localparam int JDO_ADDR_HI  = 33;
    localparam int JDO_ADDR_LO  = 26;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/nios2_oci_mem_watchdog.sv
// nios2_oci_mem_watchdog: busy-cycle watchdog for the debug-memory access FSM.
// Built only when OCI_MEM_TIMEOUT_EN is defined.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   busy       : high while a transfer is outstanding
//   expired    : high once busy has lasted TIMEOUT_CYCLES cycles
`ifdef OCI_MEM_TIMEOUT_EN
module nios2_oci_mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // counts busy cycles; cleared as soon as the FSM returns to idle
    always_ff @(posedge clk) begin
        if (reset || !busy)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/nios2_oci_mem_access.sv
// nios2_oci_mem_access: OCI debug-host access engine for the debug memory.
// Ports:
//   clk, reset                   : rising-edge clock, synchronous active-high reset
//   jdo                          : 38-bit debug command word
//   take_action_ocimem_a         : load address from jdo, read if jdo[35]
//   take_no_action_ocimem_a      : read at current address
//   take_action_ocimem_b         : write jdo[34:3] at current address
//   MonDReg                      : last read data (or timeout marker)
//   monitor_ready, monitor_error : idle indication, sticky error flag
//   mem_*                        : Avalon-style debug memory master
// Optional feature: define OCI_MEM_TIMEOUT_EN to add a transfer watchdog.
module nios2_oci_mem_access
    import nios2_oci_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid
);

    mem_state_e        state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              idle, any_strobe;
    logic              cmd_a, cmd_b, cmd_na;
    logic              rd_acc, wr_acc, rd_done;
    logic              wd_expired, timeout;
    logic              unused_jdo;

    assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

    assign idle       = (state == IDLE);
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // strobe priority: a > b > no_action_a; losers are silently dropped
    assign cmd_a  = idle && take_action_ocimem_a;
    assign cmd_b  = idle && !take_action_ocimem_a && take_action_ocimem_b;
    assign cmd_na = idle && !take_action_ocimem_a && !take_action_ocimem_b && take_no_action_ocimem_a;

    assign rd_acc  = (state == RD_REQ)  && !mem_waitrequest;
    assign wr_acc  = (state == WR_REQ)  && !mem_waitrequest;
    assign rd_done = (state == RD_WAIT) && mem_readdatavalid;

`ifdef OCI_MEM_TIMEOUT_EN
    nios2_oci_mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .busy   (!idle),
        .expired(wd_expired)
    );
`else
    // watchdog compiled out: never expires
    assign wd_expired = (TIMEOUT_CYCLES < 0);
`endif

    // a transfer completing on the expiry cycle takes precedence over the timeout
    assign timeout = wd_expired && !(rd_acc || wr_acc || rd_done);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = timeout             ? IDLE :
                    cmd_a               ? (jdo[JDO_RD_BIT] ? RD_REQ : IDLE) :
                    cmd_b               ? WR_REQ :
                    cmd_na              ? RD_REQ :
                    rd_acc              ? RD_WAIT :
                    (wr_acc || rd_done) ? IDLE :
                                          state;
    end

    always_comb begin
        mem_read      = (state == RD_REQ);
        mem_write     = (state == WR_REQ);
        monitor_ready = idle;
        mem_address   = addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr          <= '0;
            MonDReg       <= '0;
            mem_writedata <= '0;
            monitor_error <= 1'b0;
        end else begin
            if (cmd_a)
                addr <= jdo[JDO_ADDR_LO +: ADDR_W];
            else if (wr_acc || rd_done)
                addr <= addr + 1'b1;
            if (rd_done)
                MonDReg <= mem_readdata;
            else if (timeout)
                MonDReg <= TIMEOUT_DATA;
            if (cmd_b)
                mem_writedata <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
            // strobes while busy are dropped but flagged
            if ((!idle && any_strobe) || timeout)
                monitor_error <= 1'b1;
            else if (cmd_a)
                monitor_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nios2_oci_mem_access.sv
// tb_nios2_oci_mem_access: self-checking bench for nios2_oci_mem_access.
module tb_nios2_oci_mem_access;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [7:0]  mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int wr_seen = 0;

    typedef struct packed {
        logic        wr;
        logic [7:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    nios2_oci_mem_access dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .mem_address            (mem_address),
        .mem_read               (mem_read),
        .mem_write              (mem_write),
        .mem_writedata          (mem_writedata),
        .mem_waitrequest        (mem_waitrequest),
        .mem_readdata           (mem_readdata),
        .mem_readdatavalid      (mem_readdatavalid)
    );

    // scoreboard consumer: every accepted memory request must match the next expectation
    always @(negedge clk) begin
        if (!reset && (mem_read || mem_write) && !mem_waitrequest) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL mem_req unexpected: rd=%0b wr=%0b addr=%h data=%h", mem_read, mem_write, mem_address, mem_writedata);
            end else begin
                e = exp_q.pop_front();
                if ((mem_read && mem_write) || mem_write !== e.wr || mem_address !== e.a || (e.wr && mem_writedata !== e.d)) begin
                    miscompares++;
                    $display("FAIL mem_req: got rd=%0b wr=%0b addr=%h data=%h, want wr=%0b addr=%h data=%h",
                             mem_read, mem_write, mem_address, mem_writedata, e.wr, e.a, e.d);
                end
            end
            if (mem_write) wr_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic strobe(input bit a, input bit b, input bit na, input bit rd, input logic [7:0] ad, input logic [31:0] d);
        jdo = '0;
        if (b) jdo[34:3] = d;
        if (a) begin
            jdo[35]    = rd;
            jdo[33:26] = ad;
        end
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = na;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!((mem_read || mem_write) && !mem_waitrequest) && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_accept: got no accepted request in 50 cycles, want one");
        end else
            tick();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!monitor_ready && n < budget) begin
            tick();
            n++;
        end
        if (n == budget) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: got busy after %0d cycles, want idle", budget);
        end
    endtask

    task automatic pulse_valid(input logic [31:0] d);
        mem_readdata      = d;
        mem_readdatavalid = 1'b1;
        tick();
        mem_readdatavalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_ready", 32'(monitor_ready), 32'h1);
        chk("rst_error", 32'(monitor_error), 32'h0);
        chk("rst_read", 32'(mem_read), 32'h0);
        chk("rst_write", 32'(mem_write), 32'h0);
        chk("rst_addr", 32'(mem_address), 32'h0);
    endtask

    task automatic test_read();
        exp_q.push_back('{1'b0, 8'h10, 32'h0});
        strobe(1, 0, 0, 1, 8'h10, 32'h0);
        chk("rd_ready_drop", 32'(monitor_ready), 32'h0);
        wait_accept();
        repeat (2) tick();
        pulse_valid(32'hCAFE0001);
        chk("rd_mondreg", MonDReg, 32'hCAFE0001);
        chk("rd_addr", 32'(mem_address), 32'h11);
        chk("rd_ready", 32'(monitor_ready), 32'h1);
    endtask

    task automatic test_write_wrap();
        strobe(1, 0, 0, 0, 8'hFF, 32'h0);
        chk("ld_ready", 32'(monitor_ready), 32'h1);
        chk("ld_addr", 32'(mem_address), 32'hFF);
        exp_q.push_back('{1'b1, 8'hFF, 32'h12345678});
        strobe(0, 1, 0, 0, 8'h00, 32'h12345678);
        wait_accept();
        wait_idle(20);
        chk("wr_wrap_addr", 32'(mem_address), 32'h00);
    endtask

    task automatic test_waitrequest();
        int w0;
        mem_waitrequest = 1'b1;
        exp_q.push_back('{1'b1, 8'h00, 32'h0BADF00D});
        strobe(0, 1, 0, 0, 8'h00, 32'h0BADF00D);
        for (int i = 0; i < 5; i++) begin
            chk("wait_stable", {mem_write, 7'h0, mem_address, 16'h0}, {1'b1, 7'h0, 8'h00, 16'h0});
            tick();
        end
        w0 = wr_seen;
        mem_waitrequest = 1'b0;
        wait_accept();
        wait_idle(20);
        chk("wait_one_write", 32'(wr_seen - w0), 32'h1);
        chk("wait_addr", 32'(mem_address), 32'h01);
    endtask

    task automatic test_error();
        exp_q.push_back('{1'b0, 8'h01, 32'h0});
        strobe(0, 0, 1, 0, 8'h00, 32'h0);
        wait_accept();
        strobe(0, 0, 1, 0, 8'h00, 32'h0);
        chk("err_set", 32'(monitor_error), 32'h1);
        chk("err_busy", 32'(monitor_ready), 32'h0);
        pulse_valid(32'hA5A50002);
        chk("err_rd_data", MonDReg, 32'hA5A50002);
        chk("err_rd_addr", 32'(mem_address), 32'h02);
        chk("err_sticky", 32'(monitor_error), 32'h1);
        strobe(1, 0, 0, 0, 8'h20, 32'h0);
        chk("err_clear", 32'(monitor_error), 32'h0);
        chk("err_clear_addr", 32'(mem_address), 32'h20);
    endtask

    task automatic test_priority();
        strobe(1, 1, 1, 0, 8'h30, 32'hFFFFFFFF);
        tick();
        chk("pri_a_ready", 32'(monitor_ready), 32'h1);
        chk("pri_a_addr", 32'(mem_address), 32'h30);
        exp_q.push_back('{1'b1, 8'h30, 32'h5EED0030});
        strobe(0, 1, 1, 0, 8'h00, 32'h5EED0030);
        wait_accept();
        wait_idle(20);
        chk("pri_b_addr", 32'(mem_address), 32'h31);
        chk("pri_b_error", 32'(monitor_error), 32'h0);
    endtask

    task automatic test_reset_mid();
        exp_q.push_back('{1'b0, 8'h31, 32'h0});
        strobe(0, 0, 1, 0, 8'h00, 32'h0);
        wait_accept();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_valid(32'h11111111);
        tick();
        chk("mid_mondreg", MonDReg, 32'h0);
        chk("mid_addr", 32'(mem_address), 32'h0);
        chk("mid_ready", 32'(monitor_ready), 32'h1);
        chk("mid_read", 32'(mem_read), 32'h0);
    endtask

`ifdef OCI_MEM_TIMEOUT_EN
    task automatic test_timeout();
        exp_q.push_back('{1'b0, 8'h00, 32'h0});
        strobe(0, 0, 1, 0, 8'h00, 32'h0);
        wait_accept();
        wait_idle(100);
        chk("to_mondreg", MonDReg, 32'hDEADBEEF);
        chk("to_error", 32'(monitor_error), 32'h1);
        chk("to_addr", 32'(mem_address), 32'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_wrap();
        test_waitrequest();
        test_error();
        test_priority();
        test_reset_mid();
`ifdef OCI_MEM_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
